bus_dest_regs: RTL

Destination side of the processor's 16-bit internal data bus: latches the bus word into the register selected by a 4-bit destination code and returns every register's contents on dedicated outputs that feed the bus source selector. Uses the same register encoding as the source side: AR 0000, DR 0001, R1 0010, R2 0011, R3 0100, RA 0101, RB 0110, RC 0111, AC 1000, IR 1010. A valid/ready load handshake is sequenced by a small FSM that writes exactly once per request and signals completion. It sits between the control unit and the bus selector.

---
 rtl/bus_dest_regs_pkg.sv | 29 ++
 rtl/bus_dest_reg.sv | 27 ++
 rtl/bus_dest_regs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_dest_regs_pkg.sv
// Shared definitions for the internal-bus destination registers: register codes,
// code-valid check, load FSM state type and default data width.
package bus_dest_regs_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Same 4-bit register encoding the bus source selector uses
    localparam logic [3:0] SEL_AR = 4'b0000;
    localparam logic [3:0] SEL_DR = 4'b0001;
    localparam logic [3:0] SEL_R1 = 4'b0010;
    localparam logic [3:0] SEL_R2 = 4'b0011;
    localparam logic [3:0] SEL_R3 = 4'b0100;
    localparam logic [3:0] SEL_RA = 4'b0101;
    localparam logic [3:0] SEL_RB = 4'b0110;
    localparam logic [3:0] SEL_RC = 4'b0111;
    localparam logic [3:0] SEL_AC = 4'b1000;
    localparam logic [3:0] SEL_IR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic code_valid(input logic [3:0] code);
        return (code <= SEL_AC) || (code == SEL_IR);
    endfunction

endpackage

// File: rtl/bus_dest_reg.sv
// One bus destination register with fixed priority: reset > load > clear > increment.
module bus_dest_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Increment wraps naturally at the register width
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_dest_regs.sv
// Destination side of the internal data bus: handshake-driven load into ten registers.
// Optional increment strobes on AR, R1 and AC are enabled by defining BUS_DEST_INC_EN.
module bus_dest_regs
    import bus_dest_regs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             ld_valid,
    input  logic [3:0]       ld_sel,
    output logic             ld_ready,
    output logic             ld_done,
    output logic             ld_err,
`ifdef BUS_DEST_INC_EN
    input  logic             inc_ar,
    input  logic             inc_r1,
    input  logic             inc_ac,
`endif
    input  logic             clr_ac,
    output logic [WIDTH-1:0] ar_q,
    output logic [WIDTH-1:0] dr_q,
    output logic [WIDTH-1:0] r1_q,
    output logic [WIDTH-1:0] r2_q,
    output logic [WIDTH-1:0] r3_q,
    output logic [WIDTH-1:0] ra_q,
    output logic [WIDTH-1:0] rb_q,
    output logic [WIDTH-1:0] rc_q,
    output logic [WIDTH-1:0] ac_q,
    output logic [WIDTH-1:0] ir_q
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold_data;
    logic [3:0]       hold_sel;
    logic             wr_en;
    logic             inc_ar_w;
    logic             inc_r1_w;
    logic             inc_ac_w;

`ifdef BUS_DEST_INC_EN
    assign inc_ar_w = inc_ar;
    assign inc_r1_w = inc_r1;
    assign inc_ac_w = inc_ac;
`else
    assign inc_ar_w = 1'b0;
    assign inc_r1_w = 1'b0;
    assign inc_ac_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word and code are frozen at acceptance so later bus activity cannot leak in
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_sel  <= '0;
        end else if (state_q == IDLE && ld_valid) begin
            hold_data <= bus_data;
            hold_sel  <= ld_sel;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        ld_err   = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (code_valid(hold_sel)) begin
                    wr_en   = 1'b1;
                    state_d = DONE;
                end else begin
                    ld_err  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    bus_dest_reg #(.WIDTH(WIDTH)) u_ar (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_AR),
        .d   (hold_data),
        .clr (1'b0),
        .inc (inc_ar_w),
        .q   (ar_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_dr (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_DR),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (dr_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_r1 (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_R1),
        .d   (hold_data),
        .clr (1'b0),
        .inc (inc_r1_w),
        .q   (r1_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_r2 (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_R2),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (r2_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_r3 (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_R3),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (r3_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_ra (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_RA),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (ra_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_rb (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_RB),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (rb_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_rc (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_RC),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (rc_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_ac (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_AC),
        .d   (hold_data),
        .clr (clr_ac),
        .inc (inc_ac_w),
        .q   (ac_q)
    );

    bus_dest_reg #(.WIDTH(WIDTH)) u_ir (
        .clk (clk),
        .rst (rst),
        .ld  (wr_en && hold_sel == SEL_IR),
        .d   (hold_data),
        .clr (1'b0),
        .inc (1'b0),
        .q   (ir_q)
    );

endmodule
